// File: rtl/bcd_seri_toplayici_if.sv
// Operand/result bundle for the digit-serial BCD adder/subtractor.
// The master side supplies operands and start; the slave side returns status and result.
interface bcd_seri_toplayici_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic         start;
  logic         mode;
  logic         c_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         invalid;

  modport master (
    output start, mode, c_in, a, b,
    input  busy, done, sum, c_out, invalid
  );

  modport slave (
    input  start, mode, c_in, a, b,
    output busy, done, sum, c_out, invalid
  );
endinterface

// File: rtl/bcd_seri_toplayici.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first.
// Subtraction is A + 9's complement(B) + 1, so a borrow shows up as c_out = 0.
module bcd_seri_toplayici #(
  parameter int unsigned DIGITS = 4
) (
  input logic                  clk,
  input logic                  rst,
  bcd_seri_toplayici_if.slave  bus
);
  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             invalid_q, invalid_d;

  logic             bad_c;
  logic [3:0]       dig_a_c, dig_b_c, bd_c, dig_s_c;
  logic [4:0]       t_c;
  logic             carry_n_c;
  logic             last_c;

  // Any operand digit above 9 rejects the whole request.
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) bad_c = 1'b1;
    end
  end

  // Single-digit decimal adder on the current digit.
  always_comb begin
    dig_a_c = a_q[{idx_q, 2'b00} +: 4];
    dig_b_c = b_q[{idx_q, 2'b00} +: 4];
    bd_c    = mode_q ? (4'd9 - dig_b_c) : dig_b_c;
    t_c     = 5'(dig_a_c) + 5'(bd_c) + 5'(carry_q);
    if (t_c > 5'd9) begin
      dig_s_c   = 4'(t_c + 5'd6);
      carry_n_c = 1'b1;
    end else begin
      dig_s_c   = 4'(t_c);
      carry_n_c = 1'b0;
    end
    last_c = (idx_q == IDX_W'(DIGITS - 1));
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    c_out_d   = c_out_q;
    invalid_d = invalid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bad_c) begin
            invalid_d = 1'b1;
            sum_d     = '0;
            c_out_d   = 1'b0;
            done_d    = 1'b1;
          end else begin
            a_d       = bus.a;
            b_d       = bus.b;
            mode_d    = bus.mode;
            carry_d   = bus.mode ? 1'b1 : bus.c_in;
            invalid_d = 1'b0;
            idx_d     = '0;
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        sum_d[{idx_q, 2'b00} +: 4] = dig_s_c;
        carry_d                    = carry_n_c;
        if (last_c) begin
          c_out_d = carry_n_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      c_out_q   <= c_out_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum     = sum_q;
  assign bus.c_out   = c_out_q;
  assign bus.invalid = invalid_q;
endmodule

// File: tb/tb_bcd_seri_toplayici.sv
// Directed bench for the 4-digit BCD adder/subtractor: arithmetic, handshake, invalid and reset cases.
module tb_bcd_seri_toplayici;
  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  bcd_seri_toplayici_if #(.DIGITS(4)) bus ();

  bcd_seri_toplayici #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one sampling edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic m, input logic ci);
    bus.a     = av;
    bus.b     = bv;
    bus.mode  = m;
    bus.c_in  = ci;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Edges since the start-sampling edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic m, input logic ci,
                        input logic [15:0] exp_sum, input logic exp_c);
    int lat;
    start_op(av, bv, m, ci);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.c_out), 32'(exp_c));
    check({tag, "_inv"}, 32'(bus.invalid), 32'd0);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.c_in  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.c_out), 32'd0);
    check("rst_inv", 32'(bus.invalid), 32'd0);
    rst = 1'b0;
    tick();

    run_op("add1", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0);
    tick();
    check("add1_done_pulse", 32'(bus.done), 32'd0);
    check("add1_sum_hold", 32'(bus.sum), 32'h6912);
    run_op("add2", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("add3", 16'h0999, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0);
    run_op("sub1", 16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1);
    run_op("sub2", 16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0);
    run_op("sub3", 16'h4321, 16'h4321, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_op("sub_cin", 16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b1);
    tick();

    // Invalid digit in A: immediate done with cleared result.
    start_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
    check("inv_done", 32'(bus.done), 32'd1);
    check("inv_flag", 32'(bus.invalid), 32'd1);
    check("inv_sum", 32'(bus.sum), 32'd0);
    check("inv_cout", 32'(bus.c_out), 32'd0);
    check("inv_busy", 32'(bus.busy), 32'd0);
    tick();
    check("inv_done_pulse", 32'(bus.done), 32'd0);
    check("inv_busy2", 32'(bus.busy), 32'd0);
    check("inv_hold", 32'(bus.invalid), 32'd1);
    run_op("inv_clear", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    tick();

    // Invalid digit in B.
    start_op(16'h0001, 16'hF000, 1'b1, 1'b0);
    check("invb_done", 32'(bus.done), 32'd1);
    check("invb_flag", 32'(bus.invalid), 32'd1);
    tick();

    // Start and operand changes mid-calculation are ignored.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    tick();
    bus.a     = 16'h9999;
    bus.b     = 16'h9999;
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ign_busy", 32'(bus.busy), 32'd1);
    tick();
    check("ign_done", 32'(bus.done), 32'd1);
    check("ign_sum", 32'(bus.sum), 32'h3333);
    check("ign_cout", 32'(bus.c_out), 32'd0);

    // Back-to-back start during the done cycle.
    run_op("b2b1", 16'h0500, 16'h0500, 1'b0, 1'b0, 16'h1000, 1'b0);
    run_op("b2b2", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b0);
    tick();

    // Asynchronous reset in the middle of a calculation.
    start_op(16'h1357, 16'h2468, 1'b0, 1'b0);
    tick();
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_sum", 32'(bus.sum), 32'd0);
    check("mid_cout", 32'(bus.c_out), 32'd0);
    check("mid_inv", 32'(bus.invalid), 32'd0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) seen++;
    end
    check("mid_no_done", 32'(seen), 32'd0);
    run_op("post_rst", 16'h1357, 16'h2468, 1'b0, 1'b0, 16'h3825, 1'b0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
